// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared constants and width helpers for the AXI-Stream FIFO
package axis_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4096;

  // Width of a word counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Each stored entry carries tdata plus its tlast bit.
  function automatic int entry_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - simple dual-port RAM, one write port, one registered read port
module axis_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write and read register; the read register holds its value when rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_fifo_param.sv
// rtl/axis_fifo_param.sv - FWFT AXI-Stream FIFO; define AXIS_FIFO_PACKET_MODE_EN for store-and-forward
module axis_fifo_param
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 16,
  parameter int AEMPTY_TH = 16,
  localparam int CW       = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] input_tdata,
  input  logic              input_tvalid,
  output logic              input_tready,
  input  logic              input_tlast,
  output logic [DATA_W-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready,
  output logic              output_tlast,
  output logic [CW-1:0]     count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = entry_width(DATA_W);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ram_valid_q, ram_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;

  logic              push, pop, load_out, rd_en, ram_wr;
  logic              ram_empty, ram_full;
  logic              out_release, deadlock;
  logic [EW-1:0]     ram_rd_data;

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign input_tready  = w_en && ready_q && (count_q < DEPTH_C);
  assign push          = input_tvalid && input_tready;
  assign ram_wr        = push && !ram_full;
  assign output_tvalid = out_valid_q && r_en && out_release;
  assign pop           = output_tvalid && output_tready;
  // Output register refills from the RAM read register when empty or being drained.
  assign load_out      = ram_valid_q && (!out_valid_q || pop);
  // RAM read register fetches the next entry whenever it is free or handing over.
  assign rd_en         = !ram_empty && (!ram_valid_q || load_out);

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          drain_q, drain_d;

  // A full FIFO with no complete packet can never finish one, so it is drained regardless.
  assign deadlock    = (count_q == DEPTH_C) && (pkt_cnt_q == '0);
  assign out_release = (pkt_cnt_q != '0) || drain_q;

  // Complete-packet count and deadlock-drain flag.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    drain_d   = drain_q;
    if ((push && input_tlast) && !(pop && out_last_q)) begin
      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    end else if (!(push && input_tlast) && (pop && out_last_q)) begin
      pkt_cnt_d = pkt_cnt_q - CNT_ONE;
    end
    if (deadlock) begin
      drain_d = 1'b1;
    end else if ((count_d == '0) || (pop && out_last_q)) begin
      drain_d = 1'b0;
    end
  end

  // Packet-mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
      drain_q   <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      drain_q   <= drain_d;
    end
  end
`else
  assign deadlock    = 1'b0;
  assign out_release = 1'b1;
`endif

  axis_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({input_tlast, input_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  // Next-state for pointers, pipeline stages, occupancy and status flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_valid_d = ram_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    ready_d     = 1'b1;

    if (ram_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      ram_valid_d = 1'b1;
    end else if (load_out) begin
      ram_valid_d = 1'b0;
    end

    if (load_out) begin
      out_valid_d              = 1'b1;
      {out_last_d, out_data_d} = ram_rd_data;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    if ((input_tvalid && w_en && (count_q == DEPTH_C)) || deadlock) begin
      ovf_d = 1'b1;
    end

    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  // Control state register with synchronous reset; RAM contents are left as-is.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
    end
  end

  assign output_tdata = out_data_q;
  assign output_tlast = out_last_q;
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow_err = ovf_q;

endmodule
